// File: rtl/uart_capture_pkg.sv
// Shared definitions for the multi-channel UART capture block:
// receiver state encoding and the escape/command byte codes.
package uart_capture_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] ESC_CODE    = 8'h1B;
  localparam logic [7:0] CMD_DBG_ON  = 8'h11;
  localparam logic [7:0] CMD_DBG_OFF = 8'h12;
  localparam logic [7:0] CMD_SIM_END = 8'h04;

endpackage

// File: rtl/uart_capture_multi_if.sv
// Byte handshake bundle. valid/ready: a transfer happens on a rising clock edge
// where both are high; valid holds with stable data until that transfer.
interface uart_capture_multi_if #(
  parameter int DATAW = 8
);
  logic             valid;
  logic             ready;
  logic [DATAW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_capture_rx.sv
// One UART receive lane: 2-flop synchroniser, IDLE/START/DATA/STOP receiver
// and a one-entry holding register offered on the hold handshake.
module uart_capture_rx
  import uart_capture_pkg::*;
#(
  parameter int DATAW   = 8,
  parameter int BAUDDIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  uart_capture_multi_if.master  hold,
  output logic                  cap_valid_o,
  output logic [DATAW-1:0]      cap_data_o,
  input  logic                  cap_drop_i,
  output logic                  ovr_o,
  output logic                  ferr_o
);
  localparam int CW = $clog2(BAUDDIV);
  localparam int BW = $clog2(DATAW);
  localparam logic [CW-1:0] HALF_M1  = CW'(BAUDDIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(BAUDDIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAW - 1);

  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DATAW-1:0] sh_q, sh_d;
  logic             wait_hi_q, wait_hi_d;
  logic             hold_v_q, hold_v_d;
  logic [DATAW-1:0] hold_q, hold_d;
  logic             rx_s;

  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], rxd};
  assign prev_d = rx_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    sh_d        = sh_q;
    wait_hi_d   = wait_hi_q;
    cap_valid_o = 1'b0;
    ferr_o      = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[DATAW-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // After a bad stop bit the lane parks here until the line is idle again.
        if (wait_hi_q) begin
          cnt_d = '0;
          if (rx_s) begin
            wait_hi_d = 1'b0;
            state_d   = RX_IDLE;
          end
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            cap_valid_o = 1'b1;
            state_d     = RX_IDLE;
          end else begin
            ferr_o    = 1'b1;
            wait_hi_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign cap_data_o = sh_q;

  always_comb begin
    hold_v_d = hold_v_q & ~hold.ready;
    hold_d   = hold_q;
    ovr_o    = 1'b0;
    if (cap_valid_o && !cap_drop_i) begin
      if (hold_v_d) begin
        ovr_o = 1'b1;
      end else begin
        hold_v_d = 1'b1;
        hold_d   = sh_q;
      end
    end
  end

  assign hold.valid = hold_v_q;
  assign hold.data  = hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      wait_hi_q <= 1'b0;
      hold_v_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wait_hi_q <= wait_hi_d;
      hold_v_q  <= hold_v_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: rtl/uart_capture_multi.sv
// Multi-channel UART capture: NCH receive lanes drained lowest-channel-first
// into a shared FIFO, with an escape-command decoder on channel ESC_CH.
module uart_capture_multi
  import uart_capture_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DATAW   = 8,
  parameter int BAUDDIV = 16,
  parameter int DEPTH   = 8,
  parameter int ESC_CH  = 0,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NCH-1:0]   RXD,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [DATAW-1:0] OUT_DATA,
  output logic [CHW-1:0]   OUT_CH,
  output logic [AW:0]      FIFO_LEVEL,
  output logic [NCH-1:0]   OVERRUN,
  output logic [NCH-1:0]   FRAMEERR,
  input  logic             ERR_CLR,
  output logic             DEBUG_TESTER_ENABLE,
  output logic             SIMULATIONEND,
  output logic [7:0]       AUXCTRL
);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic             cap_valid [NCH];
  logic [DATAW-1:0] cap_data  [NCH];
  logic [DATAW-1:0] h_data    [NCH];
  logic [NCH-1:0]   h_valid, h_ready, ovr_set, ferr_set;
  logic             esc_drop;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    uart_capture_multi_if #(.DATAW(DATAW)) u_hold_if ();

    uart_capture_rx #(.DATAW(DATAW), .BAUDDIV(BAUDDIV)) u_rx (
      .clk        (CLK),
      .rst        (RESET),
      .rxd        (RXD[g]),
      .hold       (u_hold_if),
      .cap_valid_o(cap_valid[g]),
      .cap_data_o (cap_data[g]),
      .cap_drop_i ((g == ESC_CH) ? esc_drop : 1'b0),
      .ovr_o      (ovr_set[g]),
      .ferr_o     (ferr_set[g])
    );

    assign h_valid[g]      = u_hold_if.valid;
    assign h_data[g]       = u_hold_if.data;
    assign u_hold_if.ready = h_ready[g];
  end

  logic             armed_q, armed_d, dbg_q, dbg_d, sim_q, sim_d;
  logic [7:0]       aux_q, aux_d, esc_b;
  logic [NCH-1:0]   ovr_q, ovr_d, ferr_q, ferr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop, push, can_push;
  logic [CHW-1:0]   push_ch;
  logic [DATAW-1:0] push_data;
  logic [CHW+DATAW-1:0] mem_q [DEPTH];
  logic [CHW+DATAW-1:0] head;

  // Escape and command bytes are swallowed here and never reach the holding register.
  always_comb begin
    armed_d  = armed_q;
    dbg_d    = dbg_q;
    sim_d    = sim_q;
    aux_d    = aux_q;
    esc_drop = 1'b0;
    esc_b    = 8'(cap_data[ESC_CH]);
    if (cap_valid[ESC_CH]) begin
      if (armed_q) begin
        esc_drop = 1'b1;
        armed_d  = 1'b0;
        case (esc_b)
          CMD_DBG_ON:  dbg_d = 1'b1;
          CMD_DBG_OFF: dbg_d = 1'b0;
          CMD_SIM_END: sim_d = 1'b1;
          default:     aux_d = esc_b;
        endcase
      end else if (esc_b == ESC_CODE) begin
        esc_drop = 1'b1;
        armed_d  = 1'b1;
      end
    end
  end

  always_comb begin
    pop       = (count_q != '0) && OUT_READY;
    can_push  = (count_q != FULL) || pop;
    push      = 1'b0;
    push_ch   = '0;
    push_data = '0;
    h_ready   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (h_valid[i] && can_push && !push) begin
        push       = 1'b1;
        h_ready[i] = 1'b1;
        push_ch    = CHW'(i);
        push_data  = h_data[i];
      end
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    ovr_d  = (ERR_CLR ? '0 : ovr_q)  | ovr_set;
    ferr_d = (ERR_CLR ? '0 : ferr_q) | ferr_set;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {push_ch, push_data};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      armed_q  <= 1'b0;
      dbg_q    <= 1'b0;
      sim_q    <= 1'b0;
      aux_q    <= '0;
      ovr_q    <= '0;
      ferr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      armed_q  <= armed_d;
      dbg_q    <= dbg_d;
      sim_q    <= sim_d;
      aux_q    <= aux_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is masked while empty so the outputs read zero rather than stale storage.
  assign head                = mem_q[rd_ptr_q];
  assign OUT_VALID           = (count_q != '0);
  assign OUT_DATA            = OUT_VALID ? head[DATAW-1:0] : '0;
  assign OUT_CH              = OUT_VALID ? head[CHW+DATAW-1:DATAW] : '0;
  assign FIFO_LEVEL          = count_q;
  assign OVERRUN             = ovr_q;
  assign FRAMEERR            = ferr_q;
  assign DEBUG_TESTER_ENABLE = dbg_q;
  assign SIMULATIONEND       = sim_q;
  assign AUXCTRL             = aux_q;

endmodule
